// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: generic valid/ready pipeline stage register with a
// 2-entry skid buffer (main + skid). in_ready is driven from a flop so the
// ready path does not chain combinationally through the pipeline.
// Optional feature macro: PIPE_BUBBLE_CNT_EN (downstream-idle cycle counter).
module pipe_stage_skid #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  bubble_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] main_data, main_data_nxt;
    logic [CTRL_W-1:0] main_ctrl, main_ctrl_nxt;
    logic [DATA_W-1:0] skid_data, skid_data_nxt;
    logic [CTRL_W-1:0] skid_ctrl, skid_ctrl_nxt;
    logic              in_ready_nxt;
    logic              out_valid_nxt;
    logic              accept_c;
    logic              deliver_c;

    assign accept_c  = in_valid & in_ready;
    assign deliver_c = out_valid & out_ready;

    // main_ctrl is kept at zero whenever the stage is empty, so out_ctrl
    // needs no gating logic behind the register.
    assign out_data = main_data;
    assign out_ctrl = main_ctrl;

    // Next-state and register-update decode.
    always_comb begin
        state_nxt     = state;
        main_data_nxt = main_data;
        main_ctrl_nxt = main_ctrl;
        skid_data_nxt = skid_data;
        skid_ctrl_nxt = skid_ctrl;
        in_ready_nxt  = in_ready;
        out_valid_nxt = out_valid;

        if (flush) begin
            // Kill everything; data registers hold, only ctrl is cleared.
            state_nxt     = ST_EMPTY;
            main_ctrl_nxt = '0;
            skid_ctrl_nxt = '0;
        end else begin
            unique case (state)
                ST_EMPTY: begin
                    if (accept_c) begin
                        state_nxt     = ST_ONE;
                        main_data_nxt = in_data;
                        main_ctrl_nxt = in_ctrl;
                    end
                end
                ST_ONE: begin
                    if (accept_c && deliver_c) begin
                        main_data_nxt = in_data;
                        main_ctrl_nxt = in_ctrl;
                    end else if (accept_c) begin
                        state_nxt     = ST_TWO;
                        skid_data_nxt = in_data;
                        skid_ctrl_nxt = in_ctrl;
                    end else if (deliver_c) begin
                        state_nxt     = ST_EMPTY;
                        main_ctrl_nxt = '0;
                    end
                end
                ST_TWO: begin
                    // in_ready is low here, so only a deliver can occur.
                    if (deliver_c) begin
                        state_nxt     = ST_ONE;
                        main_data_nxt = skid_data;
                        main_ctrl_nxt = skid_ctrl;
                        skid_ctrl_nxt = '0;
                    end
                end
                default: begin
                    state_nxt     = ST_EMPTY;
                    main_ctrl_nxt = '0;
                    skid_ctrl_nxt = '0;
                end
            endcase
        end

        in_ready_nxt  = (state_nxt != ST_TWO);
        out_valid_nxt = (state_nxt != ST_EMPTY);
    end

    // State and storage registers; rst dominates flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_EMPTY;
            main_data <= '0;
            main_ctrl <= '0;
            skid_data <= '0;
            skid_ctrl <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            main_data <= main_data_nxt;
            main_ctrl <= main_ctrl_nxt;
            skid_data <= skid_data_nxt;
            skid_ctrl <= skid_ctrl_nxt;
            in_ready  <= in_ready_nxt;
            out_valid <= out_valid_nxt;
        end
    end

`ifdef PIPE_BUBBLE_CNT_EN
    logic [CNT_W-1:0] bubble_q;

    // Count cycles where downstream is ready but we have nothing; saturating.
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_q <= '0;
        end else if (out_ready && !out_valid && (bubble_q != '1)) begin
            bubble_q <= bubble_q + CNT_W'(1);
        end
    end

    assign bubble_cnt = bubble_q;
`else
    assign bubble_cnt = '0;
`endif

endmodule
